ftransform_mb_sched: RTL and testbench
======================================

// Module: ftransform_mb_sched
// PURPOSE
//  Sequences one shared 4x4 forward-DCT unit over all NUM_BLK residual blocks of a macroblock.
//  - Fetches src/ref pixel blocks from the block buffer and issues them to the transform.
//  - Captures the transform results into an output FIFO.
//  - Drains the FIFO in block order to the quantiser over a valid/ready handshake.
//  Sits between the MB pixel/prediction buffers and the quantiser stage.
// PARAMETERS
//  I_WIDTH     8   pixel width; matches transform input lanes
//  O_WIDTH     12  coefficient width; matches transform output lanes
//  NUM_BLK     16  4x4 blocks per macroblock (16 luma, 8 chroma); range 1..16
//  FIFO_DEPTH  4   coefficient FIFO entries; power of 2, >=4
// PORTS
//  clk         in   1              clock
//  rst_n       in   1              asynchronous, active-low reset
//  mb_start    in   1              1-cycle pulse: process one MB; ignored while busy=1
//  busy        out  1              high from cycle after accepted mb_start through mb_done cycle
//  mb_done     out  1              1-cycle pulse after last block accepted downstream
//  rd_en       out  1              block read request
//  rd_idx      out  4              block index of read request
//  rd_src      in   I_WIDTH*16     src block; valid exactly 1 cycle after rd_en
//  rd_ref      in   I_WIDTH*16     ref block; valid exactly 1 cycle after rd_en
//  ft_start    out  1              transform start (rd_en delayed 1 cycle)
//  ft_src      out  I_WIDTH*16     = rd_src (passthrough)
//  ft_ref      out  I_WIDTH*16     = rd_ref (passthrough)
//  ft_out      in   O_WIDTH*16     transform result; sampled when ft_done=1
//  ft_done     in   1              transform result valid (2 cycles after ft_start)
//  coef_valid  out  1              FIFO head valid
//  coef_ready  in   1              downstream accept
//  coef_data   out  O_WIDTH*16     FIFO head coefficients
//  coef_idx    out  4              block index of FIFO head
//  coef_last   out  1              coef_idx==NUM_BLK-1 (qualified by coef_valid)
// BEHAVIOUR
//  Reset: all outputs, counters, FSM and FIFO pointers are 0; FIFO is empty.
//   The transform shares rst_n, so reset mid-MB discards all in-flight work.
//  FSM:
//   IDLE  -> ISSUE on mb_start.
//   ISSUE -> DRAIN once issued==NUM_BLK.
//   DRAIN -> DONE when the last block handshakes (coef_valid & coef_ready & coef_last).
//   DONE  -> IDLE after 1 cycle; mb_done=1 only in DONE.
//   busy=1 in ISSUE, DRAIN and DONE. mb_start in any non-IDLE state is ignored.
//  Issue rule (combinational):
//   rd_en = ISSUE & issued<NUM_BLK & (fifo_cnt - pop + inflight) < FIFO_DEPTH,
//    where pop = coef_valid & coef_ready.
//   rd_idx = issued; issued increments on rd_en.
//   inflight counts rd_en not yet matched by an ft_done (max 3).
//   This credit rule guarantees the FIFO never overflows; the transform cannot be stalled.
//  ft_start is registered from rd_en. ft_src/ft_ref are combinational passthrough of rd_src/rd_ref.
//  Capture: on ft_done, push {ft_out, cap_idx}; cap_idx increments per capture.
//   ft_done with inflight==0 is ignored.
//  Output: first-word-fall-through FIFO. coef_* hold stable while coef_valid & !coef_ready.
//   Push and pop in the same cycle are both honoured.
//   Order is strictly idx 0..NUM_BLK-1.
//  Throughput: 1 block/cycle sustained when coef_ready=1.
//   Latency rd_en -> coef_valid = 4 cycles.
// TESTING
//  1 NUM_BLK=16, coef_ready=1, mb_start @c0
//    -> rd_en c1..c16 (idx 0..15); coef_valid c5..c20; mb_done c21; busy c1..c21.
//  2 coef_ready=0 throughout
//    -> exactly 4 rd_en (idx 0..3), then none.
//    Raise ready @c30 -> remaining 12 issued; output idx 0..15 in order, no loss or duplicate.
//  3 Stub transform returning ft_out = {ft_src ^ ft_ref} lanes
//    -> coef_data for idx k bit-exact to block k inputs, coef_idx=k.
//  4 Second mb_start @c10 while busy -> ignored: 16 blocks total, one mb_done.
//  5 rst_n low @c8 -> outputs 0, FIFO empty.
//    After release, new mb_start restarts at rd_idx 0.
//  6 NUM_BLK=8, random coef_ready (50%)
//    -> 8 blocks in order; coef_last only with idx 7.
//    FIFO never exceeds 4 entries; mb_done exactly once.

Source files
------------

// File: rtl/ftransform_mb_sched.sv
// ftransform_mb_sched
//   Runs one shared 4x4 forward-DCT unit over every residual block of a
//   macroblock. Blocks are read from the block buffer, passed to the
//   transform, captured into a small FWFT coefficient FIFO and drained in
//   block order to the quantiser over a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mb_start_i        pulse: process one MB (ignored while busy_o)
//   busy_o, mb_done_o MB in progress / single-cycle completion pulse
//   rd_en_o, rd_idx_o block read request and its index
//   rd_src_i/rd_ref_i block pixels, valid one cycle after rd_en_o
//   ft_start_o        transform start, rd_en_o delayed one cycle
//   ft_src_o/ft_ref_o pixel passthrough to the transform
//   ft_out_i/ft_done_i transform result and its strobe
//   coef_*            FIFO head towards the quantiser
module ftransform_mb_sched #(
    parameter int I_WIDTH    = 8,
    parameter int O_WIDTH    = 12,
    parameter int NUM_BLK    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mb_start_i,
    output logic                 busy_o,
    output logic                 mb_done_o,
    output logic                 rd_en_o,
    output logic [3:0]           rd_idx_o,
    input  logic [I_WIDTH*16-1:0] rd_src_i,
    input  logic [I_WIDTH*16-1:0] rd_ref_i,
    output logic                 ft_start_o,
    output logic [I_WIDTH*16-1:0] ft_src_o,
    output logic [I_WIDTH*16-1:0] ft_ref_o,
    input  logic [O_WIDTH*16-1:0] ft_out_i,
    input  logic                 ft_done_i,
    output logic                 coef_valid_o,
    input  logic                 coef_ready_i,
    output logic [O_WIDTH*16-1:0] coef_data_o,
    output logic [3:0]           coef_idx_o,
    output logic                 coef_last_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = O_WIDTH * 16;
    localparam int EW = DW + 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q;
    logic [4:0]      issued_q;
    logic [3:0]      cap_idx_q;
    logic [2:0]      inflight_q;
    logic            ft_start_q;

    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;

    logic            push, pop, rd_en;
    logic [CW+1:0]   credit;

    assign pop  = coef_valid_o & coef_ready_i;
    // A stray ft_done with nothing outstanding would corrupt block order.
    assign push = ft_done_i & (inflight_q != 3'd0);

    // Reserve a FIFO slot for every block already in the transform, so the
    // transform pipeline never needs back-pressure.
    assign credit = (CW+2)'(cnt_q) - (CW+2)'(pop) + (CW+2)'(inflight_q);

    always_comb begin
        rd_en = 1'b0;
        if (state_q == ISSUE && issued_q < 5'(NUM_BLK) && credit < (CW+2)'(FIFO_DEPTH))
            rd_en = 1'b1;
    end

    assign rd_en_o      = rd_en;
    assign rd_idx_o     = issued_q[3:0];
    assign ft_start_o   = ft_start_q;
    assign ft_src_o     = rd_src_i;
    assign ft_ref_o     = rd_ref_i;
    assign busy_o       = (state_q != IDLE);
    assign mb_done_o    = (state_q == DONE);
    assign coef_valid_o = (cnt_q != '0);
    assign coef_data_o  = mem_q[rd_ptr_q][EW-1:4];
    assign coef_idx_o   = mem_q[rd_ptr_q][3:0];
    assign coef_last_o  = coef_valid_o & (coef_idx_o == 4'(NUM_BLK-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            cap_idx_q  <= '0;
            inflight_q <= '0;
            ft_start_q <= 1'b0;
        end else begin
            ft_start_q <= rd_en;
            inflight_q <= inflight_q + 3'(rd_en) - 3'(push);
            if (rd_en) issued_q <= issued_q + 5'd1;
            if (push)  cap_idx_q <= cap_idx_q + 4'd1;
            case (state_q)
                IDLE: if (mb_start_i) begin
                    state_q   <= ISSUE;
                    issued_q  <= '0;
                    cap_idx_q <= '0;
                end
                ISSUE: if (issued_q == 5'(NUM_BLK)) state_q <= DRAIN;
                DRAIN: if (pop && coef_last_o)      state_q <= DONE;
                DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {ft_out_i, cap_idx_q};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_ftransform_mb_sched.sv
// Bench for ftransform_mb_sched: two instances (16 and 8 blocks) each with a
// block-buffer and 2-cycle transform stub returning src^ref per lane.
module tb_ftransform_mb_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mb_start [2];
    logic coef_ready [2];
    logic clr = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] blk(input int k, input bit is_ref);
        logic [127:0] b;
        for (int l = 0; l < 16; l++)
            b[l*8 +: 8] = is_ref ? 8'(8'h5A + l*7) : 8'(k*16 + l);
        return b;
    endfunction

    function automatic logic [191:0] xlanes(input logic [127:0] a, input logic [127:0] b);
        logic [191:0] o;
        for (int l = 0; l < 16; l++)
            o[l*12 +: 12] = {4'b0, a[l*8 +: 8] ^ b[l*8 +: 8]};
        return o;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int NB = (g == 0) ? 16 : 8;
        logic busy, mb_done, rd_en, ft_start, ft_done, coef_valid, coef_last;
        logic [3:0]   rd_idx, coef_idx;
        logic [127:0] rd_src, rd_ref, ft_src, ft_ref;
        logic [191:0] ft_out, coef_data, x1;
        logic         d1;

        ftransform_mb_sched #(.NUM_BLK(NB)) dut (
            .clk(clk), .rst_n(rst_n), .mb_start_i(mb_start[g]),
            .busy_o(busy), .mb_done_o(mb_done),
            .rd_en_o(rd_en), .rd_idx_o(rd_idx),
            .rd_src_i(rd_src), .rd_ref_i(rd_ref),
            .ft_start_o(ft_start), .ft_src_o(ft_src), .ft_ref_o(ft_ref),
            .ft_out_i(ft_out), .ft_done_i(ft_done),
            .coef_valid_o(coef_valid), .coef_ready_i(coef_ready[g]),
            .coef_data_o(coef_data), .coef_idx_o(coef_idx), .coef_last_o(coef_last)
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_src <= '0; rd_ref <= '0; d1 <= 1'b0; ft_done <= 1'b0;
                x1 <= '0; ft_out <= '0;
            end else begin
                rd_src  <= rd_en ? blk(int'(rd_idx), 1'b0) : '0;
                rd_ref  <= rd_en ? blk(int'(rd_idx), 1'b1) : '0;
                d1      <= ft_start;
                ft_done <= d1;
                x1      <= xlanes(ft_src, ft_ref);
                ft_out  <= x1;
            end
        end

        int rd_cnt, rd_first, rd_last, cv_first, cv_last, done_cnt, done_cyc;
        int busy_first, busy_last, hs, occ, max_occ, rel;
        logic pv;
        logic [191:0] pdata;
        logic [3:0]   pidx;

        initial begin
            forever begin
                @(negedge clk);
                rel = cyc - base;
                if (clr) begin
                    rd_cnt = 0; rd_first = -1; rd_last = -1; cv_first = -1; cv_last = -1;
                    done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
                    hs = 0; occ = 0; max_occ = 0; pv = 1'b0; pdata = '0; pidx = '0;
                end else begin
                    if (rd_en) begin
                        chk("rd_idx", 192'(rd_idx), 192'(rd_cnt));
                        if (rd_cnt == 0) rd_first = rel;
                        rd_last = rel;
                        rd_cnt++;
                    end
                    if (coef_valid) begin
                        if (cv_first < 0) cv_first = rel;
                        cv_last = rel;
                    end
                    if (busy) begin
                        if (busy_first < 0) busy_first = rel;
                        busy_last = rel;
                    end
                    if (pv) begin
                        chk("hold_data", coef_data, pdata);
                        chk("hold_idx", 192'(coef_idx), 192'(pidx));
                    end
                    pv = coef_valid & ~coef_ready[g];
                    pdata = coef_data; pidx = coef_idx;
                    if (coef_valid && coef_ready[g]) begin
                        chk("coef_idx", 192'(coef_idx), 192'(hs));
                        chk("coef_data", coef_data, xlanes(blk(hs, 1'b0), blk(hs, 1'b1)));
                        chk("coef_last", 192'(coef_last), 192'(hs == NB-1));
                        hs++;
                    end
                    occ = occ + int'(ft_done) - int'(coef_valid & coef_ready[g]);
                    if (occ > max_occ) max_occ = occ;
                    if (mb_done) begin done_cnt++; done_cyc = rel; end
                end
            end
        end
    end

    task automatic clear();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic start(input int g);
        @(posedge clk); #1;
        base = cyc;
        mb_start[g] = 1'b1;
        @(posedge clk); #1;
        mb_start[g] = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - base < n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int g, input int limit, input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk); #1;
            if (rnd) coef_ready[g] = 1'($urandom % 2);
            if (g == 0) ok = (u[0].done_cnt > 0) && !u[0].busy;
            else        ok = (u[1].done_cnt > 0) && !u[1].busy;
        end
        chk("wait_done", 192'(ok), 192'(1));
    endtask

    initial begin
        mb_start[0] = 1'b0; mb_start[1] = 1'b0;
        coef_ready[0] = 1'b1; coef_ready[1] = 1'b1;
        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 192'(u[0].busy), 192'(0));
        chk("rst_rd_en", 192'(u[0].rd_en), 192'(0));
        chk("rst_valid", 192'(u[0].coef_valid), 192'(0));
        chk("rst_data", u[0].coef_data, 192'(0));
        chk("rst_done", 192'(u[0].mb_done), 192'(0));
        chk("rst_ft_src", 192'(u[0].ft_src), 192'(0));
        rst_n = 1'b1;
        clear();

        // Full MB at ready=1, with an ignored second start at c10.
        start(0);
        wait_rel(10);
        mb_start[0] = 1'b1;
        @(posedge clk); #1;
        mb_start[0] = 1'b0;
        wait_idle(0, 100, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_rd_cnt", 192'(u[0].rd_cnt), 192'(16));
        chk("t1_rd_first", 192'(u[0].rd_first), 192'(1));
        chk("t1_rd_last", 192'(u[0].rd_last), 192'(16));
        chk("t1_cv_first", 192'(u[0].cv_first), 192'(5));
        chk("t1_cv_last", 192'(u[0].cv_last), 192'(20));
        chk("t1_done_cyc", 192'(u[0].done_cyc), 192'(21));
        chk("t1_done_cnt", 192'(u[0].done_cnt), 192'(1));
        chk("t1_busy_first", 192'(u[0].busy_first), 192'(1));
        chk("t1_busy_last", 192'(u[0].busy_last), 192'(21));
        chk("t1_hs", 192'(u[0].hs), 192'(16));
        chk("t1_busy_end", 192'(u[0].busy), 192'(0));

        // Back-pressure: ready low until c30.
        clear();
        coef_ready[0] = 1'b0;
        start(0);
        wait_rel(29);
        chk("t2_rd_stall", 192'(u[0].rd_cnt), 192'(4));
        chk("t2_valid", 192'(u[0].coef_valid), 192'(1));
        chk("t2_head_idx", 192'(u[0].coef_idx), 192'(0));
        chk("t2_max_occ", 192'(u[0].max_occ), 192'(4));
        wait_rel(30);
        coef_ready[0] = 1'b1;
        wait_idle(0, 100, 1'b0);
        @(negedge clk);
        chk("t2_rd_cnt", 192'(u[0].rd_cnt), 192'(16));
        chk("t2_hs", 192'(u[0].hs), 192'(16));
        chk("t2_done_cnt", 192'(u[0].done_cnt), 192'(1));

        // Reset mid-MB, then a clean restart.
        clear();
        start(0);
        wait_rel(8);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", 192'(u[0].busy), 192'(0));
        chk("t5_rd_en", 192'(u[0].rd_en), 192'(0));
        chk("t5_rd_idx", 192'(u[0].rd_idx), 192'(0));
        chk("t5_ft_start", 192'(u[0].ft_start), 192'(0));
        chk("t5_valid", 192'(u[0].coef_valid), 192'(0));
        chk("t5_data", u[0].coef_data, 192'(0));
        chk("t5_idx", 192'(u[0].coef_idx), 192'(0));
        chk("t5_done", 192'(u[0].mb_done), 192'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear();
        start(0);
        wait_idle(0, 100, 1'b0);
        @(negedge clk);
        chk("t5_rd_first", 192'(u[0].rd_first), 192'(1));
        chk("t5_rd_cnt", 192'(u[0].rd_cnt), 192'(16));
        chk("t5_hs", 192'(u[0].hs), 192'(16));
        chk("t5_done_cnt", 192'(u[0].done_cnt), 192'(1));

        // 8-block MB with random ready.
        clear();
        start(1);
        wait_idle(1, 600, 1'b1);
        coef_ready[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_rd_cnt", 192'(u[1].rd_cnt), 192'(8));
        chk("t6_hs", 192'(u[1].hs), 192'(8));
        chk("t6_done_cnt", 192'(u[1].done_cnt), 192'(1));
        chk("t6_occ_le4", 192'(u[1].max_occ <= 4), 192'(1));
        chk("t6_occ_end", 192'(u[1].occ), 192'(0));
        chk("t6_busy_end", 192'(u[1].busy), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
